// File: rtl/rv32i_defs_pkg.sv
// Shared RV32I definitions: format codes, base opcodes and loader FSM state encodings.
package rv32i_defs;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/inst_word_pack.sv
// Combinational RV32I packer: fields + immediate -> 32-bit word, with illegal-format and
// (when IMM_RANGE_CHECK_EN is defined) immediate-range flags.
module inst_word_pack
  import rv32i_defs::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o,
  output logic        range_err_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (fmt_i)
      FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
      FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: illegal_o = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // A value fits in N signed bits when everything above bit N-2 is a copy of the sign.
  function automatic logic fits_s12(input logic [31:0] v);
    return (v[31:11] == '0) || (v[31:11] == '1);
  endfunction

  function automatic logic fits_s13(input logic [31:0] v);
    return (v[31:12] == '0) || (v[31:12] == '1);
  endfunction

  function automatic logic fits_s21(input logic [31:0] v);
    return (v[31:20] == '0) || (v[31:20] == '1);
  endfunction

  always_comb begin
    range_err_o = 1'b0;
    case (fmt_i)
      FMT_I, FMT_S: range_err_o = !fits_s12(imm_i);
      FMT_B:        range_err_o = !fits_s13(imm_i) || imm_i[0];
      FMT_U:        range_err_o = (imm_i[11:0] != '0);
      FMT_J:        range_err_o = !fits_s21(imm_i) || imm_i[0];
      default:      range_err_o = 1'b0;
    endcase
  end
`else
  assign range_err_o = 1'b0;
`endif

endmodule

// File: rtl/inst_encoder_loader.sv
// Session FSM that packs field-level commands into RV32I words and streams them to imem.
// Optional immediate range checking is enabled with IMM_RANGE_CHECK_EN.
module inst_encoder_loader
  import rv32i_defs::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_fmt,
  input  logic [6:0]                 cmd_opcode,
  input  logic [2:0]                 cmd_funct3,
  input  logic [6:0]                 cmd_funct7,
  input  logic [4:0]                 cmd_rd,
  input  logic [4:0]                 cmd_rs1,
  input  logic [4:0]                 cmd_rs2,
  input  logic [31:0]                cmd_imm,
  input  logic                       cmd_last,
  output logic                       imem_we,
  output logic [ADDR_W-1:0]          imem_addr,
  output logic [31:0]                imem_wdata,
  input  logic                       imem_gnt,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(MAX_WORDS):0] word_count,
  output logic                       err_illegal,
  output logic                       err_range
);

  localparam int CW = $clog2(MAX_WORDS) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              err_ill_q, err_ill_d;
  logic              err_rng_q, err_rng_d;

  logic [31:0] pack_word;
  logic        pack_illegal;
  logic        pack_range_err;

  inst_word_pack u_pack (
    .fmt_i       (cmd_fmt),
    .opcode_i    (cmd_opcode),
    .funct3_i    (cmd_funct3),
    .funct7_i    (cmd_funct7),
    .rd_i        (cmd_rd),
    .rs1_i       (cmd_rs1),
    .rs2_i       (cmd_rs2),
    .imm_i       (cmd_imm),
    .word_o      (pack_word),
    .illegal_o   (pack_illegal),
    .range_err_o (pack_range_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      err_ill_q <= 1'b0;
      err_rng_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      err_ill_q <= err_ill_d;
      err_rng_q <= err_rng_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    err_ill_d = err_ill_q;
    err_rng_d = err_rng_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d    = base_addr & ~ADDR_W'(3);
          cnt_d     = '0;
          err_ill_d = 1'b0;
          err_rng_d = 1'b0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cmd_valid) begin
          last_d = cmd_last;
          // Rejected commands are dropped in place; cmd_last still closes the session.
          if (pack_illegal || pack_range_err) begin
            err_ill_d = err_ill_q | pack_illegal;
            err_rng_d = err_rng_q | (!pack_illegal && pack_range_err);
            state_d   = cmd_last ? ST_DONE : ST_RUN;
          end else begin
            wdata_d = pack_word;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (imem_gnt) begin
          addr_d  = addr_q + ADDR_W'(4);
          cnt_d   = cnt_q + CW'(1);
          state_d = (last_q || (cnt_q + CW'(1) == CW'(MAX_WORDS))) ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == ST_RUN);
  assign imem_we     = (state_q == ST_WRITE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign word_count  = cnt_q;
  assign err_illegal = err_ill_q;
  assign err_range   = err_rng_q;

endmodule
